// File: rtl/sram_fifo_if.sv
// Producer/consumer handshake bundle for sram_fifo.
// The flush_en signal exists only when FIFO_FLUSH_EN is defined.
interface sram_fifo_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  enqueue_en;
  logic [DATA_WIDTH-1:0] enqueue_value;
  logic                  full;
  logic                  almost_full;
  logic                  dequeue_en;
  logic [DATA_WIDTH-1:0] dequeue_value;
  logic                  empty;
  logic [CW-1:0]         count;
`ifdef FIFO_FLUSH_EN
  logic                  flush_en;

  modport master (
    output enqueue_en, enqueue_value, dequeue_en, flush_en,
    input  full, almost_full, dequeue_value, empty, count
  );
  modport slave (
    input  enqueue_en, enqueue_value, dequeue_en, flush_en,
    output full, almost_full, dequeue_value, empty, count
  );
`else
  modport master (
    output enqueue_en, enqueue_value, dequeue_en,
    input  full, almost_full, dequeue_value, empty, count
  );
  modport slave (
    input  enqueue_en, enqueue_value, dequeue_en,
    output full, almost_full, dequeue_value, empty, count
  );
`endif
endinterface

// File: rtl/sram_fifo.sv
// First-word-fall-through FIFO controller over a 1W/1R storage array with
// 1-cycle registered reads and write bypass. Optional flush: FIFO_FLUSH_EN.
module sram_fifo #(
  parameter int DEPTH                 = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1
) (
  input  logic         clk,
  input  logic         reset_n,
  sram_fifo_if.slave   fifo
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESHOLD);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  use_ram_q, use_ram_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic                  rd_en;
  logic [PW-1:0]         rd_addr;

  logic                  flush;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_cur;

`ifdef FIFO_FLUSH_EN
  assign flush = fifo.flush_en;
`else
  assign flush = 1'b0;
`endif

  assign push = fifo.enqueue_en && (!full_q || fifo.dequeue_en) && !flush;
  assign pop  = fifo.dequeue_en && !empty_q && !flush;

  // The head is the prefetched array word for one cycle after a pop, else the head register.
  assign head_cur = use_ram_q ? ram_rd_q : head_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_cur;
    use_ram_d = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q + PW'(1);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      // The pushed word becomes the head right away; otherwise prefetch the next-oldest.
      if (push && (count_q == '0 || (count_q == CW'(1) && pop))) begin
        head_d = fifo.enqueue_value;
      end else if (pop && count_q > CW'(1)) begin
        rd_en     = 1'b1;
        use_ram_d = 1'b1;
      end
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= (AF_C == '0);
      head_q    <= '0;
      use_ram_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      head_q    <= head_d;
      use_ram_q <= use_ram_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy tracking makes stale words invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= fifo.enqueue_value;
    if (rd_en) begin
      ram_rd_q <= (push && wr_ptr_q == rd_addr) ? fifo.enqueue_value : mem[rd_addr];
    end
  end

  assign fifo.full          = full_q;
  assign fifo.almost_full   = af_q;
  assign fifo.empty         = empty_q;
  assign fifo.count         = count_q;
  assign fifo.dequeue_value = head_cur;

endmodule

// File: tb/tb_sram_fifo.sv
// Self-checking bench for sram_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sram_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AF_TH = DEPTH - 1;

  logic clk;
  logic reset_n;

  sram_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) fifo_if ();

  sram_fifo #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .ALMOST_FULL_THRESHOLD(AF_TH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fifo(fifo_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] dv_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 64'(fifo_if.count), 64'(model_q.size()));
    check({tag, ".empty"}, 64'(fifo_if.empty), 64'(model_q.size() == 0));
    check({tag, ".full"},  64'(fifo_if.full),  64'(model_q.size() == DEPTH));
    check({tag, ".afull"}, 64'(fifo_if.almost_full), 64'(model_q.size() >= AF_TH));
    check({tag, ".dv"},    64'(fifo_if.dequeue_value), 64'(dv_exp));
  endtask

  // One clock: drive inputs, advance the model, check outputs at the next negedge.
  task automatic step(input string tag, input logic en, input logic [DW-1:0] val,
                      input logic de, input logic fl);
    bit do_push, do_pop;
    fifo_if.enqueue_en    = en;
    fifo_if.enqueue_value = val;
    fifo_if.dequeue_en    = de;
`ifdef FIFO_FLUSH_EN
    fifo_if.flush_en      = fl;
`endif
    if (fl) begin
`ifdef FIFO_FLUSH_EN
      model_q.delete();
`endif
    end else begin
      do_push = en && (model_q.size() < DEPTH || de);
      do_pop  = de && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(val);
    end
    if (model_q.size() > 0) dv_exp = model_q[0];
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n               = 1'b0;
    fifo_if.enqueue_en    = 1'b0;
    fifo_if.enqueue_value = '0;
    fifo_if.dequeue_en    = 1'b0;
`ifdef FIFO_FLUSH_EN
    fifo_if.flush_en      = 1'b0;
`endif
    model_q.delete();
    dv_exp = '0;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset("reset");
    for (int i = 0; i < 3; i++) step("idle", 1'b0, '0, 1'b0, 1'b0);

    // Fill, overflow attempt, drain.
    step("fill1", 1'b1, 32'h11, 1'b0, 1'b0);
    step("fill2", 1'b1, 32'h22, 1'b0, 1'b0);
    step("fill3", 1'b1, 32'h33, 1'b0, 1'b0);
    step("fill4", 1'b1, 32'h44, 1'b0, 1'b0);
    step("ovf",   1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("drain_idle", 1'b0, '0, 1'b1, 1'b0);

    // Push into empty, then push+pop at count 1.
    step("a5", 1'b1, 32'hA5, 1'b0, 1'b0);
    step("b6", 1'b1, 32'hB6, 1'b1, 1'b0);
    step("b6_pop", 1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous push/pop across pointer wrap.
    for (int i = 1; i <= 4; i++) step("wfill", 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 5; i <= 12; i++) step("wrap", 1'b1, DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("wdrain", 1'b0, '0, 1'b1, 1'b0);

    // Dequeue on empty with same-cycle enqueue: no pass-through.
    step("no_pass", 1'b1, 32'h77, 1'b1, 1'b0);
    step("p2", 1'b1, 32'h78, 1'b0, 1'b0);
    step("p3", 1'b1, 32'h79, 1'b0, 1'b0);
    do_reset("mid_reset");
    step("post_reset", 1'b0, '0, 1'b1, 1'b0);

`ifdef FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) step("fl_fill", 1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
    step("flush", 1'b1, 32'hEE, 1'b1, 1'b1);
    step("fl_push", 1'b1, 32'h99, 1'b0, 1'b0);
    step("fl_pop", 1'b0, '0, 1'b1, 1'b0);
`endif

    // Random traffic with occasional reset and flush.
    for (int i = 0; i < 600; i++) begin
      logic en, de, fl;
      en = ($urandom_range(0, 99) < 55);
      de = ($urandom_range(0, 99) < 50);
      fl = 1'b0;
`ifdef FIFO_FLUSH_EN
      fl = ($urandom_range(0, 99) < 3);
`endif
      if ($urandom_range(0, 99) < 2) do_reset("rnd_reset");
      else step("rnd", en, DW'($urandom), de, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_fifo.md
Name: sram_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO built on a 1-write/1-read storage array.
- The storage array has registered, 1-cycle read latency and same-address write-to-read bypass.
- The block is the controller for that array. It owns the write and read pointers, the occupancy count, and a prefetch/head register that hides the read latency from the consumer.
- Used between core pipeline stages and for writeback and request queues.

Parameters:
- DEPTH, 4, total entries the FIFO can hold; power of 2, minimum 2.
- DATA_WIDTH, 32, width of each entry in bits.
- ALMOST_FULL_THRESHOLD, DEPTH-1, almost_full asserts when count >= this value; range 1..DEPTH.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset_n  input  1  synchronous active-low reset.
- enqueue_en  input  1  push enqueue_value this cycle.
- enqueue_value  input  DATA_WIDTH  data to push.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= ALMOST_FULL_THRESHOLD.
- dequeue_en  input  1  pop the head entry this cycle.
- dequeue_value  output  DATA_WIDTH  head entry; valid whenever empty == 0.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- flush_en  input  1  present only with FIFO_FLUSH_EN; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n: sampled on posedge clk while reset_n == 0.
- Reset values:
  - empty = 1, full = 0, almost_full = 0 (or 1 if ALMOST_FULL_THRESHOLD == 0, which is illegal), count = 0.
  - dequeue_value = 0; pointers = 0.
  - Storage contents are not reset.
- Reset mid-operation: all in-flight entries are discarded; the next cycle shows the empty state above.
- Accepted events:
  - push = enqueue_en && (!full || dequeue_en).
  - pop = dequeue_en && !empty.
- Enqueue while full without a same-cycle dequeue: ignored. No state change and no corruption.
- Dequeue while empty: ignored, even if enqueue_en is high the same cycle. There is no same-cycle pass-through.
- Count update: count_next = count + push - pop.
- Pointer arithmetic: write/read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case at wrap. full and empty are derived from count, never from pointer equality.
- Status outputs: full, empty, almost_full and count are registered, updated the cycle after the push/pop.
- Latency: a push into an empty FIFO in cycle N gives empty = 0 and dequeue_value = pushed data in cycle N+1.
- FWFT head:
  - dequeue_value always presents the oldest entry while empty == 0.
  - After a pop in cycle N, dequeue_value shows the next-oldest entry in cycle N+1, or empty = 1 if none remain.
  - The 1-cycle storage latency must be covered. A prefetch read is issued in the same cycle as the pop. The head register is loaded directly from enqueue_value when the entry being pushed becomes the head in the same cycle:
    - count == 0 and a push occurs; or
    - count == 1 and both a push and a pop occur.
- Same-address case: a read and a write to the same storage address in one cycle must return the new write data. This relies on the storage bypass.
- Full with simultaneous push and pop: both accepted. count stays DEPTH; the head advances; data order is preserved.
- dequeue_value: holds its last value when empty == 1. Consumers must not use it while empty.

Optional Feature:
- Macro: FIFO_FLUSH_EN.
- Defined:
  - Adds the flush_en input.
  - flush_en == 1 at posedge clears count and pointers next cycle: empty = 1, full = 0, almost_full = 0.
  - flush_en has priority over enqueue_en and dequeue_en in the same cycle; both are dropped.
  - reset_n == 0 has priority over flush_en.
- Undefined: the port does not exist and the FIFO can only be emptied by dequeueing or reset.

Test Plan:
- Reset, then idle 3 cycles -> empty = 1, full = 0, count = 0, dequeue_value = 0 throughout.
- DEPTH = 4: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1, 2, 3, 4; almost_full at count 3; full at count 4. A push of 0x55 while full is ignored. Then dequeue 4 times -> dequeue_value 0x11, 0x22, 0x33, 0x44, then empty = 1.
- Empty FIFO, push 0xA5 in cycle N -> cycle N+1: empty = 0, dequeue_value = 0xA5. Push 0xB6 and pop in the same cycle -> next cycle dequeue_value = 0xB6, count = 1.
- Full FIFO holding 1, 2, 3, 4; push 5 and pop in the same cycle, repeated 8 cycles with pushes 5..12 (pointer wrap) -> count stays 4; popped sequence is 1..8; remaining entries are 9..12.
- Empty FIFO, dequeue_en and enqueue_en both high with 0x77 -> dequeue ignored; next cycle count = 1, dequeue_value = 0x77. Assert reset_n = 0 with 3 entries -> next cycle empty = 1, count = 0.
- FIFO_FLUSH_EN: 3 entries stored; flush_en asserted together with enqueue_en -> next cycle empty = 1, count = 0, enqueued data is not present. A subsequent push of 0x99 appears at dequeue_value one cycle later.
